// File: rtl/mac_sequencer_if.sv
// Job, tap-stream, MAC-drive and result signals of one mac_sequencer.
// master = the sequencer itself; slave = the surrounding fetch/MAC/writer logic.
interface mac_sequencer_if #(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int TAP_WIDTH = 8
);
    localparam int RES_WIDTH = IMG_WIDTH + KER_WIDTH + 1;

    logic                 start;
    logic [TAP_WIDTH-1:0] cfg_taps;
    logic                 busy;
    logic [IMG_WIDTH-1:0] up_img;
    logic [KER_WIDTH-1:0] up_ker;
    logic                 up_valid;
    logic                 up_ready;
    logic                 mac_rst;
    logic [IMG_WIDTH-1:0] mac_img;
    logic [KER_WIDTH-1:0] mac_ker;
    logic                 mac_val;
    logic [RES_WIDTH-1:0] mac_result;
    logic [RES_WIDTH-1:0] res_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [2:0]           dbg_state;

    modport master (
        input  start, cfg_taps, up_img, up_ker, up_valid, mac_result, res_ready,
        output busy, up_ready, mac_rst, mac_img, mac_ker, mac_val, res_data, res_valid, dbg_state
    );

    modport slave (
        output start, cfg_taps, up_img, up_ker, up_valid, mac_result, res_ready,
        input  busy, up_ready, mac_rst, mac_img, mac_ker, mac_val, res_data, res_valid, dbg_state
    );
endinterface

// File: rtl/mac_sequencer.sv
// Drives one multiply_acc through complete dot-product jobs: clear, stream taps,
// drain the MAC pipeline, then hold the captured sum until the writer takes it.
module mac_sequencer #(
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int TAP_WIDTH   = 8,
    parameter int MAC_LATENCY = 5
) (
    input  logic             clk,
    input  logic             rst,
    mac_sequencer_if.master  bus
);
    localparam int RES_WIDTH = IMG_WIDTH + KER_WIDTH + 1;
    localparam int DRAIN_W   = $clog2(MAC_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic [TAP_WIDTH-1:0] r_tap_left;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_busy;
    logic                 r_up_ready;
    logic                 r_res_valid;
    logic [RES_WIDTH-1:0] r_res_data;
    logic                 w_xfer;

    // Both streams use valid/ready: a beat moves on a rising edge where valid and
    // ready are both high; the producer holds its data until that edge.
    assign w_xfer = bus.up_valid & r_up_ready;

    assign bus.busy      = r_busy;
    assign bus.up_ready  = r_up_ready;
    assign bus.mac_rst   = rst | (r_state == S_CLEAR);
    assign bus.mac_img   = bus.up_img;
    assign bus.mac_ker   = bus.up_ker;
    assign bus.mac_val   = w_xfer;
    assign bus.res_data  = r_res_data;
    assign bus.res_valid = r_res_valid;
    assign bus.dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tap_left  <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_up_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A zero-tap request has nothing to sum and is dropped.
                    if (bus.start && (bus.cfg_taps != '0)) begin
                        r_tap_left <= bus.cfg_taps;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_up_ready <= 1'b1;
                    r_state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_tap_left <= r_tap_left - 1'b1;
                        if (r_tap_left == TAP_WIDTH'(1)) begin
                            r_up_ready  <= 1'b0;
                            r_drain_cnt <= DRAIN_W'(MAC_LATENCY);
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last tap is inside mac_result on the edge where the count hits zero.
                    r_drain_cnt <= r_drain_cnt - 1'b1;
                    if (r_drain_cnt == DRAIN_W'(1)) begin
                        r_res_data  <= bus.mac_result;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_up_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
